// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the inverter-chain delay-line sensor: launch, capture, convert, settle,
// averaged over 2^LOG2_AVG samples. Optional min/max tracking via `define TDC_MINMAX_TRACK_EN.
module tdc_meas_ctrl #(
  parameter int unsigned N_TAPS     = 16,
  parameter int unsigned LOG2_AVG   = 3,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = $clog2(N_TAPS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_TAPS-1:0]         tap_in,
  output logic                      launch,
  output logic                      busy,
  output logic                      result_valid,
  output logic [CNT_W-1:0]          result_avg,
  output logic [CNT_W+LOG2_AVG-1:0] result_sum,
  output logic                      overflow
`ifdef TDC_MINMAX_TRACK_EN
  ,
  output logic [CNT_W-1:0]          result_min,
  output logic [CNT_W-1:0]          result_max
`endif
);

  localparam int unsigned SUM_W  = CNT_W + LOG2_AVG;
  localparam int unsigned SCNT_W = LOG2_AVG + 1;
  localparam int unsigned STL_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [SCNT_W-1:0] LastSample = SCNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [STL_W-1:0]  LastSettle = STL_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  FullCode   = CNT_W'(N_TAPS);

  typedef enum logic [2:0] {StIdle, StLaunch, StCapture, StSettle, StDone} state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [STL_W-1:0]   stl_q, stl_d;
  logic               ovf_run_q, ovf_run_d;
  logic [SUM_W-1:0]   result_sum_q, result_sum_d;
  logic [CNT_W-1:0]   result_avg_q, result_avg_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   code;
  logic               run;

  // Count leading ones from tap 0; anything after the first zero is a bubble and is ignored.
  always_comb begin
    code = '0;
    run  = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (run && tap_in[i]) begin
        code = CNT_W'(i + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

`ifdef TDC_MINMAX_TRACK_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] result_min_q, result_min_d, result_max_q, result_max_d;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    scnt_d       = scnt_q;
    stl_d        = stl_q;
    ovf_run_d    = ovf_run_q;
    result_sum_d = result_sum_q;
    result_avg_d = result_avg_q;
    overflow_d   = overflow_q;
`ifdef TDC_MINMAX_TRACK_EN
    min_d        = min_q;
    max_d        = max_q;
    result_min_d = result_min_q;
    result_max_d = result_max_q;
`endif
    launch       = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StLaunch;
          acc_d     = '0;
          scnt_d    = '0;
          ovf_run_d = 1'b0;
`ifdef TDC_MINMAX_TRACK_EN
          min_d     = FullCode;
          max_d     = '0;
`endif
        end
      end
      StLaunch: begin
        launch  = 1'b1;
        busy    = 1'b1;
        state_d = abort ? StIdle : StCapture;
      end
      StCapture: begin
        launch = 1'b1;
        busy   = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d     = acc_q + SUM_W'(code);
          ovf_run_d = ovf_run_q | (code == FullCode);
`ifdef TDC_MINMAX_TRACK_EN
          if (code < min_q) min_d = code;
          if (code > max_q) max_d = code;
`endif
          stl_d     = '0;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        busy = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (stl_q == LastSettle) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q < LastSample) begin
            state_d = StLaunch;
          end else begin
            // Load results on entry so they are already visible during the DONE cycle.
            state_d      = StDone;
            result_sum_d = acc_q;
            result_avg_d = acc_q[SUM_W-1:LOG2_AVG];
            overflow_d   = ovf_run_q;
`ifdef TDC_MINMAX_TRACK_EN
            result_min_d = min_q;
            result_max_d = max_q;
`endif
          end
        end else begin
          stl_d = stl_q + 1'b1;
        end
      end
      StDone: begin
        result_valid = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      scnt_q       <= '0;
      stl_q        <= '0;
      ovf_run_q    <= 1'b0;
      result_sum_q <= '0;
      result_avg_q <= '0;
      overflow_q   <= 1'b0;
`ifdef TDC_MINMAX_TRACK_EN
      min_q        <= FullCode;
      max_q        <= '0;
      result_min_q <= '1;
      result_max_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      scnt_q       <= scnt_d;
      stl_q        <= stl_d;
      ovf_run_q    <= ovf_run_d;
      result_sum_q <= result_sum_d;
      result_avg_q <= result_avg_d;
      overflow_q   <= overflow_d;
`ifdef TDC_MINMAX_TRACK_EN
      min_q        <= min_d;
      max_q        <= max_d;
      result_min_q <= result_min_d;
      result_max_q <= result_max_d;
`endif
    end
  end

  assign result_sum = result_sum_q;
  assign result_avg = result_avg_q;
  assign overflow   = overflow_q;
`ifdef TDC_MINMAX_TRACK_EN
  assign result_min = result_min_q;
  assign result_max = result_max_q;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed, table-driven bench for tdc_meas_ctrl at default parameters.
// Min/max checks are compiled in when TDC_MINMAX_TRACK_EN is defined.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] tap_in;
  logic        launch, busy, result_valid, overflow;
  logic [4:0]  result_avg;
  logic [7:0]  result_sum;
`ifdef TDC_MINMAX_TRACK_EN
  logic [4:0]  result_min, result_max;
`endif

  tdc_meas_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .tap_in       (tap_in),
    .launch       (launch),
    .busy         (busy),
    .result_valid (result_valid),
    .result_avg   (result_avg),
    .result_sum   (result_sum),
    .overflow     (overflow)
`ifdef TDC_MINMAX_TRACK_EN
    ,
    .result_min   (result_min),
    .result_max   (result_max)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tb;
    logic [7:0]  sum;
    logic [4:0]  avg;
    logic        ovf;
    logic [4:0]  mn;
    logic [4:0]  mx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at posedge+1. Cycle 0 carries start; tap ta feeds even samples, tb odd samples.
  // kind: 0 plain, 1 extra start, 2 abort, 3 rst, applied in cycle ctl_cyc.
  task automatic measure(input logic [15:0] ta, input logic [15:0] tb, input int ctl_cyc,
                         input int kind, output int vcyc, output int vcnt, output int perr);
    logic exp_active, exp_launch, exp_valid;
    vcyc = -1;
    vcnt = 0;
    perr = 0;
    for (int c = 0; c < 40; c++) begin
      start  = (c == 0) || (kind == 1 && c == ctl_cyc);
      abort  = (kind == 2 && c == ctl_cyc);
      rst    = (kind == 3 && c == ctl_cyc);
      tap_in = (c >= 1 && (((c - 1) / 4) % 2 == 1)) ? tb : ta;
      #1;
      exp_active = (c >= 1) && (c <= 32) && !(kind >= 2 && c > ctl_cyc);
      exp_launch = exp_active && (((c - 1) % 4) < 2);
      exp_valid  = (c == 33) && (kind < 2);
      if (launch !== exp_launch || busy !== exp_active || result_valid !== exp_valid) perr++;
      if (result_valid === 1'b1) begin
        vcnt++;
        if (vcyc < 0) vcyc = c;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  int vcyc, vcnt, perr;

  initial begin
    vecs[0] = '{16'h00FF, 16'h00FF, 8'd64,  5'd8,  1'b0, 5'd8,  5'd8};
    vecs[1] = '{16'h00F7, 16'h00F7, 8'd24,  5'd3,  1'b0, 5'd3,  5'd3};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 8'd128, 5'd16, 1'b1, 5'd16, 5'd16};
    vecs[3] = '{16'h000F, 16'h000F, 8'd32,  5'd4,  1'b0, 5'd4,  5'd4};
    vecs[4] = '{16'h0001, 16'h0003, 8'd12,  5'd1,  1'b0, 5'd1,  5'd2};
    vecs[5] = '{16'h0007, 16'h003F, 8'd36,  5'd4,  1'b0, 5'd3,  5'd6};
    vecs[6] = '{16'h0000, 16'h0000, 8'd0,   5'd0,  1'b0, 5'd0,  5'd0};

    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    tap_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_launch", 32'(launch), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_sum", 32'(result_sum), 32'd0);
    check("reset_avg", 32'(result_avg), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
`ifdef TDC_MINMAX_TRACK_EN
    check("reset_min", 32'(result_min), 32'd31);
    check("reset_max", 32'(result_max), 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      measure(vecs[v].ta, vecs[v].tb, 0, 0, vcyc, vcnt, perr);
      check($sformatf("v%0d_valid_cycle", v), 32'(vcyc), 32'd33);
      check($sformatf("v%0d_valid_count", v), 32'(vcnt), 32'd1);
      check($sformatf("v%0d_pattern", v), 32'(perr), 32'd0);
      check($sformatf("v%0d_sum", v), 32'(result_sum), 32'(vecs[v].sum));
      check($sformatf("v%0d_avg", v), 32'(result_avg), 32'(vecs[v].avg));
      check($sformatf("v%0d_ovf", v), 32'(overflow), 32'(vecs[v].ovf));
`ifdef TDC_MINMAX_TRACK_EN
      check($sformatf("v%0d_min", v), 32'(result_min), 32'(vecs[v].mn));
      check($sformatf("v%0d_max", v), 32'(result_max), 32'(vecs[v].mx));
`endif
    end

    // Second start mid-run is ignored.
    measure(16'h00FF, 16'h00FF, 10, 1, vcyc, vcnt, perr);
    check("restart_valid_cycle", 32'(vcyc), 32'd33);
    check("restart_valid_count", 32'(vcnt), 32'd1);
    check("restart_pattern", 32'(perr), 32'd0);
    check("restart_sum", 32'(result_sum), 32'd64);

    // Abort keeps the previous results (64 / 8).
    measure(16'h0001, 16'h0001, 10, 2, vcyc, vcnt, perr);
    check("abort_valid_count", 32'(vcnt), 32'd0);
    check("abort_pattern", 32'(perr), 32'd0);
    check("abort_sum_held", 32'(result_sum), 32'd64);
    check("abort_avg_held", 32'(result_avg), 32'd8);

    // Overflow run, then reset mid-run must clear every result.
    measure(16'hFFFF, 16'hFFFF, 0, 0, vcyc, vcnt, perr);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    measure(16'h00FF, 16'h00FF, 10, 3, vcyc, vcnt, perr);
    check("rst_valid_count", 32'(vcnt), 32'd0);
    check("rst_pattern", 32'(perr), 32'd0);
    check("rst_sum", 32'(result_sum), 32'd0);
    check("rst_avg", 32'(result_avg), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Abort beats start while idle.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_launch", 32'(launch), 32'd0);
    @(posedge clk);
    #2;
    check("abort_start_busy2", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
